// File: rtl/bno085_spi_pkg.sv
// Shared types and constants for the BNO085 SPI bus arbiter.
package bno085_spi_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACTIVE,
    DRAIN,
    GUARD
  } arb_state_t;

endpackage

// File: rtl/bno085_rr_pick.sv
// Two-input round-robin picker: on a tie, the requester that was not served last wins.
module bno085_rr_pick
  import bno085_spi_pkg::*;
(
  input  logic [NUM_REQ-1:0] eligible,
  input  logic               last,
  output logic [NUM_REQ-1:0] pick,
  output logic               valid
);

  always_comb begin
    pick = eligible;
    if (&eligible) begin
      pick = last ? 2'b01 : 2'b10;
    end
  end

  assign valid = |eligible;

endmodule

// File: rtl/bno085_spi_arbiter.sv
// Shares one SPI byte engine between two BNO085 controllers: round-robin grant,
// chip-select setup/guard timing, byte routing, MISO steering and transaction timeout.
module bno085_spi_arbiter
  import bno085_spi_pkg::*;
#(
  parameter int CS_SETUP_CYCLES = 4,
  parameter int CS_GUARD_CYCLES = 8,
  parameter int TIMEOUT_CYCLES  = 65535
) (
  input  logic               clk,
  input  logic               fpga_rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  input  logic [NUM_REQ-1:0] start_i,
  input  logic [7:0]         tx_byte_0,
  input  logic [7:0]         tx_byte_1,
  output logic [NUM_REQ-1:0] done_o,
  output logic [7:0]         rx_byte,
  output logic               eng_start,
  output logic [7:0]         eng_tx_byte,
  input  logic               eng_busy,
  input  logic               eng_done,
  input  logic [7:0]         eng_rx_byte,
  input  logic               miso1,
  input  logic               miso2,
  output logic               eng_miso,
  output logic               cs_n1,
  output logic               cs_n2,
  output logic [NUM_REQ-1:0] timeout_err
);

  localparam int SW = $clog2(CS_SETUP_CYCLES + 1);
  localparam int GW = $clog2(CS_GUARD_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SETUP_LAST = SW'(CS_SETUP_CYCLES - 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(CS_GUARD_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  arb_state_t         state_reg;
  logic               owner_reg;
  logic [NUM_REQ-1:0] mask_reg;
  logic [SW-1:0]      setup_cnt_reg;
  logic [GW-1:0]      guard_cnt_reg;
  logic [TW-1:0]      tmo_cnt_reg;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] pick;
  logic               pick_valid;

  assign eligible = req & ~mask_reg;

  bno085_rr_pick u_pick (
    .eligible (eligible),
    .last     (owner_reg),
    .pick     (pick),
    .valid    (pick_valid)
  );

  always_ff @(posedge clk or posedge fpga_rst) begin
    if (fpga_rst) begin
      state_reg     <= IDLE;
      owner_reg     <= 1'b1;
      mask_reg      <= '0;
      setup_cnt_reg <= '0;
      guard_cnt_reg <= '0;
      tmo_cnt_reg   <= '0;
      gnt           <= '0;
      cs_n1         <= 1'b1;
      cs_n2         <= 1'b1;
      eng_start     <= 1'b0;
      eng_tx_byte   <= '0;
      timeout_err   <= '0;
    end else begin
      eng_start   <= 1'b0;
      timeout_err <= '0;
      // A timed-out requester stays masked until it lets go of req.
      mask_reg    <= mask_reg & req;

      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            gnt           <= pick;
            cs_n1         <= ~pick[0];
            cs_n2         <= ~pick[1];
            owner_reg     <= pick[1];
            setup_cnt_reg <= '0;
            state_reg     <= SETUP;
          end
        end

        SETUP: begin
          if (!req[owner_reg]) begin
            gnt           <= '0;
            cs_n1         <= 1'b1;
            cs_n2         <= 1'b1;
            guard_cnt_reg <= '0;
            state_reg     <= GUARD;
          end else if (setup_cnt_reg == SETUP_LAST) begin
            tmo_cnt_reg <= '0;
            state_reg   <= ACTIVE;
          end else begin
            setup_cnt_reg <= setup_cnt_reg + SW'(1);
          end
        end

        // The timeout also covers DRAIN so a hung engine cannot hold the bus forever.
        ACTIVE, DRAIN: begin
          if (eng_done) begin
            tmo_cnt_reg <= '0;
          end else if (tmo_cnt_reg != TMO_LAST) begin
            tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
          end

          if (!eng_done && tmo_cnt_reg == TMO_LAST) begin
            timeout_err[owner_reg] <= 1'b1;
            mask_reg[owner_reg]    <= 1'b1;
            gnt                    <= '0;
            cs_n1                  <= 1'b1;
            cs_n2                  <= 1'b1;
            guard_cnt_reg          <= '0;
            state_reg              <= GUARD;
          end else if (state_reg == DRAIN) begin
            if (eng_done) begin
              gnt           <= '0;
              cs_n1         <= 1'b1;
              cs_n2         <= 1'b1;
              guard_cnt_reg <= '0;
              state_reg     <= GUARD;
            end
          end else if (!req[owner_reg]) begin
            if (eng_busy || eng_start) begin
              state_reg <= DRAIN;
            end else begin
              gnt           <= '0;
              cs_n1         <= 1'b1;
              cs_n2         <= 1'b1;
              guard_cnt_reg <= '0;
              state_reg     <= GUARD;
            end
          end else if (start_i[owner_reg] && !eng_busy && !eng_start) begin
            // A start issued last cycle has not raised eng_busy yet; don't double-issue.
            eng_start   <= 1'b1;
            eng_tx_byte <= owner_reg ? tx_byte_1 : tx_byte_0;
          end
        end

        GUARD: begin
          if (guard_cnt_reg == GUARD_LAST) begin
            state_reg <= IDLE;
          end else begin
            guard_cnt_reg <= guard_cnt_reg + GW'(1);
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_done
    assign done_o[gi] = eng_done & gnt[gi];
  end

  assign rx_byte = eng_rx_byte;

  always_comb begin
    eng_miso = 1'b0;
    case (gnt)
      2'b01:   eng_miso = miso1;
      2'b10:   eng_miso = miso2;
      default: eng_miso = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_bno085_spi_arbiter.sv
// Directed bench for bno085_spi_arbiter with hand-computed expectations.
module tb_bno085_spi_arbiter;

  logic       clk = 1'b0;
  logic       fpga_rst;
  logic [1:0] req;
  logic [1:0] gnt;
  logic [1:0] start_i;
  logic [7:0] tx_byte_0, tx_byte_1;
  logic [1:0] done_o;
  logic [7:0] rx_byte;
  logic       eng_start;
  logic [7:0] eng_tx_byte;
  logic       eng_busy, eng_done;
  logic [7:0] eng_rx_byte;
  logic       miso1, miso2, eng_miso;
  logic       cs_n1, cs_n2;
  logic [1:0] timeout_err;

  bno085_spi_arbiter #(
    .CS_SETUP_CYCLES (4),
    .CS_GUARD_CYCLES (8),
    .TIMEOUT_CYCLES  (16)
  ) dut (
    .clk         (clk),
    .fpga_rst    (fpga_rst),
    .req         (req),
    .gnt         (gnt),
    .start_i     (start_i),
    .tx_byte_0   (tx_byte_0),
    .tx_byte_1   (tx_byte_1),
    .done_o      (done_o),
    .rx_byte     (rx_byte),
    .eng_start   (eng_start),
    .eng_tx_byte (eng_tx_byte),
    .eng_busy    (eng_busy),
    .eng_done    (eng_done),
    .eng_rx_byte (eng_rx_byte),
    .miso1       (miso1),
    .miso2       (miso2),
    .eng_miso    (eng_miso),
    .cs_n1       (cs_n1),
    .cs_n2       (cs_n2),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input string tag, input logic [1:0] exp);
    int k = 0;
    while (gnt == 2'b00 && k < 40) begin
      tick();
      k++;
    end
    check(tag, gnt, exp);
    $display("txn %s: gnt=%b after %0d clocks", tag, gnt, k);
  endtask

  logic both_low   = 1'b0;
  logic cs_gnt_bad = 1'b0;
  always @(negedge clk) begin
    if (!cs_n1 && !cs_n2) both_low = 1'b1;
    if (cs_n1 !== ~gnt[0] || cs_n2 !== ~gnt[1]) cs_gnt_bad = 1'b1;
  end

  logic       flag;
  logic [1:0] exp_g;
  logic       owner;

  initial begin
    fpga_rst = 1'b1; req = '0; start_i = '0; tx_byte_0 = '0; tx_byte_1 = '0;
    eng_busy = 1'b0; eng_done = 1'b0; eng_rx_byte = '0; miso1 = 1'b0; miso2 = 1'b0;
    tick(2);
    check("rst_gnt", gnt, 2'b00);
    check("rst_cs_n1", cs_n1, 1'b1);
    check("rst_cs_n2", cs_n2, 1'b1);
    check("rst_eng_start", eng_start, 1'b0);
    check("rst_eng_tx_byte", eng_tx_byte, 8'h00);
    check("rst_timeout_err", timeout_err, 2'b00);
    fpga_rst = 1'b0;
    tick();

    // Single request: grant next edge, first start 5 clocks after CS falls.
    req = 2'b01;
    tick();
    check("t1_gnt", gnt, 2'b01);
    check("t1_cs_n1", cs_n1, 1'b0);
    check("t1_cs_n2", cs_n2, 1'b1);
    start_i = 2'b01; tx_byte_0 = 8'hA5;
    flag = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (eng_start) flag = 1'b1;
    end
    check("t1_no_early_start", flag, 1'b0);
    tick();
    check("t1_eng_start", eng_start, 1'b1);
    check("t1_eng_tx_byte", eng_tx_byte, 8'hA5);
    start_i = 2'b00;
    tick();
    check("t1_start_pulse", eng_start, 1'b0);
    eng_busy = 1'b1;
    tick();
    eng_busy = 1'b0; eng_done = 1'b1; eng_rx_byte = 8'h3C;
    #1;
    check("t1_done_o", done_o, 2'b01);
    check("t1_rx_byte", rx_byte, 8'h3C);
    tick();
    eng_done = 1'b0;
    #1;
    check("t1_done_clear", done_o, 2'b00);
    req = 2'b00;
    tick();
    check("t1_rel_gnt", gnt, 2'b00);
    check("t1_rel_cs_n1", cs_n1, 1'b1);
    flag = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tick();
      if (gnt != 2'b00 || !cs_n1) flag = 1'b1;
    end
    check("t1_guard_cs_high", flag, 1'b0);
    $display("txn t1: single request byte A5 served, released");

    // Simultaneous requests from reset: 0 first, then 1 after 8 guard clocks + 1 idle clock.
    fpga_rst = 1'b1; tick(); fpga_rst = 1'b0;
    req = 2'b11;
    tick();
    check("t2_first_gnt", gnt, 2'b01);
    tick(4);
    req = 2'b10;
    tick();
    check("t2_rel_gnt", gnt, 2'b00);
    miso1 = 1'b1; miso2 = 1'b1;
    #1;
    check("t2_miso_idle", eng_miso, 1'b0);
    flag = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (gnt != 2'b00) flag = 1'b1;
    end
    check("t2_guard_len", flag, 1'b0);
    tick();
    check("t2_second_gnt", gnt, 2'b10);
    check("t2_cs_n2", cs_n2, 1'b0);
    check("t2_cs_n1", cs_n1, 1'b1);
    miso2 = 1'b0;
    #1;
    check("t2_miso2_lo", eng_miso, 1'b0);
    miso2 = 1'b1;
    #1;
    check("t2_miso2_hi", eng_miso, 1'b1);
    tick(4);
    start_i = 2'b01; tx_byte_0 = 8'h11;
    tick();
    check("t2_wrong_side_start", eng_start, 1'b0);
    start_i = 2'b10; tx_byte_1 = 8'h5A;
    tick();
    check("t2_eng_start", eng_start, 1'b1);
    check("t2_eng_tx_byte", eng_tx_byte, 8'h5A);
    eng_busy = 1'b1;
    tick();
    check("t2_busy_start_dropped", eng_start, 1'b0);
    start_i = 2'b00; eng_busy = 1'b0; eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    $display("txn t2: req=11 served 0 then 1");

    // Alternation: each owner releases and re-requests while the other keeps asking.
    owner = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      req = 2'b11;
      req[owner] = 1'b0;
      tick();
      req = 2'b11;
      wait_grant($sformatf("t3_alt%0d", i), exp_g);
      owner = exp_g[1];
      tick(4);
    end

    // Release while engine busy goes through DRAIN; CS held until eng_done.
    start_i = 2'b10; tx_byte_1 = 8'h77;
    tick();
    check("t4_eng_start", eng_start, 1'b1);
    start_i = 2'b00; eng_busy = 1'b1; req = 2'b01;
    tick();
    check("t4_drain_cs_n2", cs_n2, 1'b0);
    tick(3);
    check("t4_drain_hold", cs_n2, 1'b0);
    eng_busy = 1'b0; eng_done = 1'b1;
    #1;
    check("t4_drain_done_o", done_o, 2'b10);
    tick();
    eng_done = 1'b0;
    check("t4_guard_cs_n2", cs_n2, 1'b1);
    check("t4_guard_gnt", gnt, 2'b00);
    wait_grant("t4_next", 2'b01);

    // Timeout after 16 clocks in ACTIVE, then masking until req toggles.
    fpga_rst = 1'b1; tick(); fpga_rst = 1'b0;
    req = 2'b01;
    tick();
    tick(4);
    tick(15);
    check("t5_pre_timeout_err", timeout_err, 2'b00);
    check("t5_pre_timeout_gnt", gnt, 2'b01);
    tick();
    check("t5_timeout_err", timeout_err, 2'b01);
    check("t5_timeout_gnt", gnt, 2'b00);
    check("t5_timeout_cs_n1", cs_n1, 1'b1);
    tick();
    check("t5_timeout_pulse", timeout_err, 2'b00);
    flag = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (gnt != 2'b00) flag = 1'b1;
    end
    check("t5_masked", flag, 1'b0);
    req = 2'b00;
    tick();
    req = 2'b01;
    wait_grant("t5_regrant", 2'b01);

    // Asynchronous reset in ACTIVE, checked before the next clock edge.
    tick(4);
    start_i = 2'b01; tx_byte_0 = 8'hC3;
    tick();
    check("t6_tx_byte", eng_tx_byte, 8'hC3);
    start_i = 2'b00;
    #2;
    fpga_rst = 1'b1;
    #1;
    check("t6_rst_gnt", gnt, 2'b00);
    check("t6_rst_cs_n1", cs_n1, 1'b1);
    check("t6_rst_eng_start", eng_start, 1'b0);
    check("t6_rst_eng_tx_byte", eng_tx_byte, 8'h00);
    req = 2'b00;
    tick();
    fpga_rst = 1'b0;
    tick();
    $display("txn t6: async reset in ACTIVE");

    check("cs_never_both_low", both_low, 1'b0);
    check("cs_matches_gnt", cs_gnt_bad, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
